branch_sequencer: RTL and testbench

Sequences the pipeline after the execute stage resolves a branch. It accepts one resolved-branch event per cycle from the branch condition logic. For a taken branch it drives a registered PC redirect to fetch over a valid/ready handshake and kills the younger IF/ID slots for a fixed window. It also produces the BL link-register write and keeps saturating taken/not-taken statistics.

---
 rtl/branch_pkg.sv | 18 +
 rtl/sat_counter16.sv | 20 ++
 rtl/branch_sequencer.sv | 132 +++++++++++++
 tb/tb_branch_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared constants and types for the branch sequencer slice.
package branch_pkg;

    localparam int unsigned CNT_W       = 16;
    localparam int unsigned LINK_OFFSET = 4;

    localparam logic [1:0] OP_B    = 2'b00;
    localparam logic [1:0] OP_BL   = 2'b01;
    localparam logic [1:0] OP_BX   = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter16.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter16
    import branch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on enable, holding at the maximum value instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Turns a resolved branch from EX into a registered fetch redirect, a fixed
// IF/ID kill window, a BL link write and taken/not-taken statistics.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic [1:0]        br_opcode,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] br_reg_target,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              redirect_ready,
    output logic              flush_if,
    output logic              flush_id,
    output logic              busy,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_data,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  not_taken_cnt,
    output logic              proto_err
);

    state_t            state_q, state_d;
    logic [2:0]        flush_cnt_q, flush_cnt_d;
    logic [ADDR_W-1:0] target_sel;
    logic              take_br;
    logic              not_take_br;
    logic              bad_br;
    logic              is_bl;
    logic              handshake;

    // Only IDLE accepts branches; reserved opcodes and anything arriving while
    // busy are protocol errors and leave all statistics untouched.
    assign take_br     = (state_q == IDLE) && br_valid && br_taken && (br_opcode != OP_RSVD);
    assign not_take_br = (state_q == IDLE) && br_valid && !br_taken && (br_opcode != OP_RSVD);
    assign bad_br      = br_valid && ((state_q != IDLE) || (br_opcode == OP_RSVD));
    assign is_bl       = (br_opcode == OP_BL);
    assign handshake   = (state_q == REDIRECT) && redirect_valid && redirect_ready;

    // BX targets are halfword aligned by clearing bit 0.
    assign target_sel = (br_opcode == OP_BX) ? (br_reg_target & ~ADDR_W'(1)) : br_target;

    // Next-state logic for the redirect/flush sequence.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (take_br) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                if (handshake) begin
                    if (FLUSH_DEPTH == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = FLUSH;
                        flush_cnt_d = 3'(FLUSH_DEPTH - 1);
                    end
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q - 3'd1;
                if (flush_cnt_q == 3'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and all outputs are flops; outputs are derived from next-state so
    // they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            flush_cnt_q    <= 3'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_if       <= 1'b0;
            flush_id       <= 1'b0;
            busy           <= 1'b0;
            link_we        <= 1'b0;
            link_data      <= '0;
            proto_err      <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            redirect_valid <= (state_d == REDIRECT);
            flush_if       <= (state_d != IDLE);
            flush_id       <= (state_d != IDLE);
            busy           <= (state_d != IDLE);
            link_we        <= take_br && is_bl;
            if (take_br) begin
                redirect_pc <= target_sel;
            end else if (handshake) begin
                redirect_pc <= '0;
            end
            if (take_br && is_bl) begin
                link_data <= br_pc + ADDR_W'(LINK_OFFSET);
            end
            if (bad_br) begin
                proto_err <= 1'b1;
            end
        end
    end

    sat_counter16 u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (take_br),
        .count (taken_cnt)
    );

    sat_counter16 u_not_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (not_take_br),
        .count (not_taken_cnt)
    );

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer with hand-computed expectations.
module tb_branch_sequencer;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              br_valid = 1'b0;
    logic              br_taken = 1'b0;
    logic [1:0]        br_opcode = 2'b00;
    logic [ADDR_W-1:0] br_pc = '0;
    logic [ADDR_W-1:0] br_target = '0;
    logic [ADDR_W-1:0] br_reg_target = '0;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              redirect_ready = 1'b0;
    logic              flush_if;
    logic              flush_id;
    logic              busy;
    logic              link_we;
    logic [ADDR_W-1:0] link_data;
    logic [15:0]       taken_cnt;
    logic [15:0]       not_taken_cnt;
    logic              proto_err;

    int checks   = 0;
    int failures = 0;

    branch_sequencer #(
        .FLUSH_DEPTH (2),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .br_valid       (br_valid),
        .br_taken       (br_taken),
        .br_opcode      (br_opcode),
        .br_pc          (br_pc),
        .br_target      (br_target),
        .br_reg_target  (br_reg_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .busy           (busy),
        .link_we        (link_we),
        .link_data      (link_data),
        .taken_cnt      (taken_cnt),
        .not_taken_cnt  (not_taken_cnt),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; sampling happens 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic taken, input logic [1:0] op, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic [31:0] rtgt);
        br_valid      = 1'b1;
        br_taken      = taken;
        br_opcode     = op;
        br_pc         = pc;
        br_target     = tgt;
        br_reg_target = rtgt;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int nf;
        int nr;
        int pc_bad;

        // Power-on reset values.
        tick();
        tick();
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_flush_if", 32'(flush_if), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_counts", {taken_cnt, not_taken_cnt}, 32'd0);
        rst = 1'b0;
        tick();

        // Reset while a redirect is held off by fetch.
        redirect_ready = 1'b0;
        present(1'b1, 2'b00, 32'h0, 32'h0000_1000, 32'h0);
        tick();
        br_valid = 1'b0;
        check("mid_rv", 32'(redirect_valid), 32'd1);
        check("mid_pc", redirect_pc, 32'h0000_1000);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {26'd0, redirect_valid, flush_if, flush_id, busy, link_we, proto_err},
              32'd0);
        check("mid_rst_pc", redirect_pc, 32'd0);
        check("mid_rst_taken", 32'(taken_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_after_rv", 32'(redirect_valid), 32'd0);
        check("mid_after_busy", 32'(busy), 32'd0);

        // B taken, fetch always ready.
        redirect_ready = 1'b1;
        present(1'b1, 2'b00, 32'h100, 32'h140, 32'h0);
        tick();
        br_valid = 1'b0;
        check("b_t1_rv", 32'(redirect_valid), 32'd1);
        check("b_t1_pc", redirect_pc, 32'h140);
        check("b_t1_flush", {30'd0, flush_if, flush_id}, 32'd3);
        check("b_t1_link_we", 32'(link_we), 32'd0);
        check("b_t1_taken", 32'(taken_cnt), 32'd1);
        tick();
        check("b_t2_rv", 32'(redirect_valid), 32'd0);
        check("b_t2_flush", {30'd0, flush_if, flush_id}, 32'd3);
        check("b_t2_busy", 32'(busy), 32'd1);
        tick();
        check("b_t3_flush", 32'(flush_if), 32'd0);
        check("b_t3_busy", 32'(busy), 32'd0);

        // BL with three cycles of backpressure.
        redirect_ready = 1'b0;
        present(1'b1, 2'b01, 32'h200, 32'h80, 32'h0);
        tick();
        br_valid = 1'b0;
        check("bl_link_we", 32'(link_we), 32'd1);
        check("bl_link_data", link_data, 32'h204);
        nf = 0;
        nr = 0;
        pc_bad = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            if (flush_if) nf++;
            if (redirect_valid) begin
                nr++;
                if (redirect_pc != 32'h80) pc_bad++;
            end
            if (i == 1) check("bl_link_we_drop", 32'(link_we), 32'd0);
            redirect_ready = (i >= 3);
            tick();
        end
        check("bl_busy_done", 32'(busy), 32'd0);
        check("bl_flush_cycles", 32'(nf), 32'd5);
        check("bl_redirect_cycles", 32'(nr), 32'd4);
        check("bl_pc_stable", 32'(pc_bad), 32'd0);

        // BX clears bit 0 of the register target.
        redirect_ready = 1'b1;
        present(1'b1, 2'b10, 32'h300, 32'h5555, 32'h0000_3001);
        tick();
        br_valid = 1'b0;
        check("bx_pc", redirect_pc, 32'h0000_3000);
        check("bx_link_we", 32'(link_we), 32'd0);
        tick();
        tick();

        // BL link address wraps.
        present(1'b1, 2'b01, 32'hFFFF_FFFE, 32'h10, 32'h0);
        tick();
        br_valid = 1'b0;
        check("wrap_link_we", 32'(link_we), 32'd1);
        check("wrap_link_data", link_data, 32'h0000_0002);
        tick();
        tick();
        check("taken_total", 32'(taken_cnt), 32'd4);

        // Not-taken saturation.
        pulse_reset();
        present(1'b0, 2'b00, 32'h400, 32'h440, 32'h0);
        tick();
        check("nt_first", 32'(not_taken_cnt), 32'd1);
        check("nt_quiet", {28'd0, redirect_valid, flush_if, busy, link_we}, 32'd0);
        repeat (16'hFFFE) tick();
        check("nt_at_max", 32'(not_taken_cnt), 32'h0000_FFFF);
        repeat (2) tick();
        br_valid = 1'b0;
        check("nt_saturated", 32'(not_taken_cnt), 32'h0000_FFFF);
        check("nt_taken_zero", 32'(taken_cnt), 32'd0);

        // Reserved opcode in IDLE.
        pulse_reset();
        present(1'b1, 2'b11, 32'h500, 32'h540, 32'h0);
        tick();
        br_valid = 1'b0;
        check("rsvd_err", 32'(proto_err), 32'd1);
        check("rsvd_quiet", {29'd0, redirect_valid, busy, link_we}, 32'd0);
        check("rsvd_counts", {taken_cnt, not_taken_cnt}, 32'd0);

        // Branch presented during FLUSH is dropped.
        pulse_reset();
        present(1'b1, 2'b00, 32'h600, 32'h640, 32'h0);
        tick();
        br_valid = 1'b0;
        tick();
        check("fl_in_flush", {30'd0, flush_if, redirect_valid}, 32'd2);
        present(1'b1, 2'b01, 32'h700, 32'h740, 32'h0);
        tick();
        br_valid = 1'b0;
        check("fl_err", 32'(proto_err), 32'd1);
        check("fl_quiet", {29'd0, redirect_valid, busy, link_we}, 32'd0);
        check("fl_counts", {taken_cnt, not_taken_cnt}, 32'h0001_0000);
        repeat (5) tick();
        check("fl_err_sticky", 32'(proto_err), 32'd1);
        rst = 1'b1;
        #1;
        check("fl_err_cleared", 32'(proto_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
